riscv_imem_port_arbiter: RTL
============================

// Module: riscv_imem_port_arbiter
// PURPOSE
//  Shares the single 128-bit instruction-memory/icache port between two fetch requesters:
//  m0 = core L0 buffer fetch, m1 = secondary refill (debug/prefetch engine).
//  Sits between the L0 buffer instr_* interface and the icache.
//  Round-robin arbitration, with an urgent override for m0 (branch/hwloop redirect).
//  Tracks outstanding grants in order and routes each rvalid/rdata back to its owner.
// PARAMETERS
//  RDATA_WIDTH      128  width of instruction fetch data (4 x 32-bit words)
//  MAX_OUTSTANDING  2    max granted-but-not-returned transactions (1..4)
// PORTS
//  clk          in   1    clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  m0_req_i     in   1    m0 request; held with m0_addr_i stable until m0_gnt_o
//  m0_urgent_i  in   1    m0 redirect; m0 wins arbitration this cycle regardless of RR state
//  m0_addr_i    in   32   m0 fetch address (line aligned by requester)
//  m0_gnt_o     out  1    m0 request accepted this cycle
//  m0_rvalid_o  out  1    m0 response data valid
//  m0_rdata_o   out  RDATA_WIDTH  m0 response data
//  m1_req_i / m1_addr_i / m1_gnt_o / m1_rvalid_o / m1_rdata_o   same as m0, no urgent input
//  mem_req_o    out  1    request to memory
//  mem_addr_o   out  32   {addr[31:4],4'b0} of the selected master
//  mem_gnt_i    in   1    memory accepted mem_req_o
//  mem_rvalid_i in   1    memory response valid, strictly in order of grants
//  mem_rdata_i  in   RDATA_WIDTH  memory response data
//  busy_o       out  1    outstanding != 0 or mem_req_o
//  err_o        out  1    sticky: rvalid received with no outstanding entry
// BEHAVIOUR
//  Reset: all outputs 0; rr_last = m1 (m0 preferred first); outstanding count = 0; err_o = 0.
//  Selection (comb): urgent & m0_req -> m0; else only one requesting -> that one;
//    both requesting -> the one not equal to rr_last.
//  Issue: mem_req_o = (m0_req_i|m1_req_i) & (count < MAX_OUTSTANDING).
//    mem_req_o/mem_addr_o never depend on mem_rvalid_i (no rvalid->req comb path).
//  Grant: mx_gnt_o = mem_req_o & mem_gnt_i & (sel == x). Zero-latency pass-through; one grant max per cycle.
//  On grant: push owner ID into in-order tracker; rr_last <= granted master.
//    Urgent grants also update rr_last.
//  Selection may change between cycles while ungranted (urgent override).
//    The memory side tolerates address change before gnt, as the L0 buffer already does.
//  Response: on mem_rvalid_i pop head ID; drive that master's rvalid_o = 1 in the same cycle (comb).
//  rdata: both mx_rdata_o = mem_rdata_i at all times; only the owner's rvalid is raised.
//  Simultaneous push+pop: count unchanged, FIFO order preserved.
//    At count == MAX, a pop does not enable a grant in the same cycle.
//  rvalid with count == 0: no rvalid_o raised, count stays 0, err_o <= 1 until reset.
//  No abort: a master that drops interest still receives its rvalid; requester discards it
//    (the L0 ABORTED_BRANCH state does this).
//  Reset mid-operation: tracker cleared, in-flight responses after reset are treated as errors.
//  Latency: req->gnt 0 cycles when port free; gnt->rvalid set by memory; arbiter adds 0 cycles.
// STRUCTURE
//  Shared package riscv_fetch_pkg: ARB_M0/ARB_M1 owner-ID encodings,
//    FETCH_LINE_OFFSET = 4, default RDATA_WIDTH.
//  Sub-module riscv_owner_fifo: MAX_OUTSTANDING-deep 1-bit FIFO with push/pop/count/empty/full,
//    pointer wrap modulo depth, simultaneous push/pop supported.
//  Top: comb selector + rr_last flop + routing; about 150-250 lines total.
// TESTING
//  m0 only, addr 0x0000_1234, gnt same cycle -> mem_addr_o=0x0000_1230, m0_gnt_o=1;
//    rvalid 2 cycles later -> m0_rvalid_o=1, m1_rvalid_o=0.
//  Both request continuously, gnt every cycle -> grants alternate m0,m1,m0,m1;
//    rvalids routed in the same order.
//  Both request, rr_last=m0, m0_urgent_i=1 -> m0 granted; next cycle without urgent -> m1 granted.
//  MAX=2: two grants, no rvalid -> mem_req_o=0 while requests are pending;
//    rvalid arrives -> mem_req_o=1 the next cycle.
//  Push+pop same cycle at count=1 -> count stays 1, next rvalid goes to the newer owner.
//  rvalid with count=0 -> err_o=1 and stays 1; assert rst_n=0 mid-burst
//    -> all outputs 0 and count 0 asynchronously.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-path definitions: owner IDs for the instruction-port arbiter,
// fetch-line geometry and the line-alignment helper.
package riscv_fetch_pkg;

    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_owner_e;

    localparam int FETCH_LINE_OFFSET   = 4;
    localparam int RDATA_WIDTH_DEFAULT = 128;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~((32'd1 << FETCH_LINE_OFFSET) - 32'd1);
    endfunction

endpackage

// File: rtl/riscv_owner_fifo.sv
// In-order tracker of granted-but-unanswered fetches: one owner ID per entry,
// simultaneous push and pop allowed, pointers wrap modulo DEPTH.
module riscv_owner_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  arb_owner_e       push_id,
    input  logic             pop,
    output arb_owner_e       head_id,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    arb_owner_e       slot_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : ptr + PTR_W'(1);
    endfunction

    assign empty     = (count_r == CNT_W'(0));
    assign full      = (count_r == CNT_W'(DEPTH));
    assign count     = count_r;
    assign head_id   = slot_r[rd_ptr_r];
    // A pop frees the slot, so a full FIFO still accepts a push in the same cycle.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Entry storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_r[i] <= ARB_M0;
            end
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
        end else begin
            if (do_push_s) begin
                slot_r[wr_ptr_r] <= push_id;
                wr_ptr_r         <= next_ptr(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
        end
    end

    // Occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_W'(0);
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/riscv_imem_port_arbiter.sv
// Round-robin arbiter sharing the instruction-memory port between the L0 fetch (m0,
// with urgent redirect override) and the secondary refill engine (m1); routes responses in order.
module riscv_imem_port_arbiter
    import riscv_fetch_pkg::*;
#(
    parameter int RDATA_WIDTH     = RDATA_WIDTH_DEFAULT,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   m0_req_i,
    input  logic                   m0_urgent_i,
    input  logic [31:0]            m0_addr_i,
    output logic                   m0_gnt_o,
    output logic                   m0_rvalid_o,
    output logic [RDATA_WIDTH-1:0] m0_rdata_o,
    input  logic                   m1_req_i,
    input  logic [31:0]            m1_addr_i,
    output logic                   m1_gnt_o,
    output logic                   m1_rvalid_o,
    output logic [RDATA_WIDTH-1:0] m1_rdata_o,
    output logic                   mem_req_o,
    output logic [31:0]            mem_addr_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [RDATA_WIDTH-1:0] mem_rdata_i,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_owner_e       sel_s;
    arb_owner_e       rr_last_r;
    arb_owner_e       head_s;
    logic [31:0]      sel_addr_s;
    logic [CNT_W-1:0] count_s;
    logic             any_req_s;
    logic             can_issue_s;
    logic             grant_s;
    logic             pop_s;
    logic             empty_s;
    logic             full_s;
    logic             err_r;

    // Master selection: urgent m0 first, then the lone requester, else the one not served last.
    always_comb begin
        sel_s = ARB_M0;
        if (m0_urgent_i && m0_req_i) begin
            sel_s = ARB_M0;
        end else if (m0_req_i && !m1_req_i) begin
            sel_s = ARB_M0;
        end else if (!m0_req_i && m1_req_i) begin
            sel_s = ARB_M1;
        end else if (m0_req_i && m1_req_i) begin
            sel_s = (rr_last_r == ARB_M0) ? ARB_M1 : ARB_M0;
        end else begin
            sel_s = ARB_M0;
        end
    end

    // Issue depends only on the registered count, never on mem_rvalid_i.
    assign any_req_s   = m0_req_i | m1_req_i;
    assign can_issue_s = (count_s < CNT_W'(MAX_OUTSTANDING));
    assign sel_addr_s  = (sel_s == ARB_M0) ? m0_addr_i : m1_addr_i;

    assign mem_req_o   = rst_n & any_req_s & can_issue_s;
    assign mem_addr_o  = (rst_n && any_req_s) ? line_align(sel_addr_s) : 32'h0000_0000;
    assign grant_s     = mem_req_o & mem_gnt_i;
    assign m0_gnt_o    = grant_s & (sel_s == ARB_M0);
    assign m1_gnt_o    = grant_s & (sel_s == ARB_M1);

    assign pop_s       = mem_rvalid_i & ~empty_s;
    assign m0_rvalid_o = pop_s & (head_s == ARB_M0);
    assign m1_rvalid_o = pop_s & (head_s == ARB_M1);
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;

    assign busy_o      = (count_s != CNT_W'(0)) | mem_req_o;
    assign err_o       = err_r;

    riscv_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (grant_s),
        .push_id (sel_s),
        .pop     (pop_s),
        .head_id (head_s),
        .count   (count_s),
        .empty   (empty_s),
        .full    (full_s)
    );

    // Round-robin history: remembers the last granted master, urgent grants included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_r <= ARB_M1;
        end else if (grant_s) begin
            rr_last_r <= sel_s;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

    // Sticky error on a response that has no outstanding owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (mem_rvalid_i && empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    logic unused_s;
    assign unused_s = full_s;

endmodule
